// File: rtl/tube_pkg.sv
// Shared constants and state encoding for the multiplexed tube scan driver.
package tube_pkg;

    // Segment encoding is {a,b,c,d,e,f,g,dp}, active-high.
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;

    // Per-cycle display state within a digit slot.
    typedef logic state_t;
    localparam state_t ST_SHOW  = 1'b0;
    localparam state_t ST_BLANK = 1'b1;

endpackage

// File: rtl/scan_prescaler.sv
// Slot counter for the tube scanner: counts 0..SCAN_DIV-1 while running,
// flags the last cycle of a slot and the blanked tail of a slot.
// Blanking is only generated when TUBE_SCAN_BLANK_EN is defined.
module scan_prescaler
    import tube_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000,
    localparam int CNT_W    = $clog2(SCAN_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic slot_wrap,
    output logic in_blank
);

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW_END = CNT_W'(SCAN_DIV - BLANK_CYC);

`ifdef TUBE_SCAN_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic [CNT_W-1:0] cnt_q;

    assign slot_wrap = run && (cnt_q == CNT_LAST);
    assign in_blank  = BLANK_ON && (cnt_q >= CNT_SHOW_END);

    // Free-running slot counter, parked at zero while not running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!run || slot_wrap) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/tube_scan_driver.sv
// Eight-digit tube scanner: two segment buses each drive one of four digits
// per slot; inputs are snapshotted once per frame so a frame never tears.
// Build option: define TUBE_SCAN_BLANK_EN to blank the tail of every slot.
module tube_scan_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [63:0] seg_in,
    input  logic [7:0]  tub_en,
    output logic [7:0]  seg_l,
    output logic [7:0]  seg_r,
    output logic [7:0]  tub_sel,
    output logic        frame_done
);

    import tube_pkg::*;

    logic        slot_wrap;
    logic        in_blank;
    state_t      state;

    logic        en_q;
    logic [1:0]  idx_q, idx_d;
    logic [63:0] shadow_seg_q, shadow_seg_d;
    logic [7:0]  shadow_en_q, shadow_en_d;
    logic [7:0]  seg_l_q, seg_l_d;
    logic [7:0]  seg_r_q, seg_r_d;
    logic [7:0]  tub_sel_q, tub_sel_d;
    logic        frame_done_q, frame_done_d;

    logic        load_first;
    logic        load_frame;
    logic [63:0] seg_eff;
    logic [7:0]  en_eff;
    logic [2:0]  digit_l, digit_r;

    scan_prescaler #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (enable),
        .slot_wrap (slot_wrap),
        .in_blank  (in_blank)
    );

    assign state = in_blank ? ST_BLANK : ST_SHOW;

    // Next-state for slot index, snapshots and the registered pin values.
    always_comb begin
        load_first = enable && !en_q;
        load_frame = slot_wrap && (idx_q == 2'd3);

        // The first enabled cycle must already show the fresh snapshot.
        seg_eff = load_first ? seg_in : shadow_seg_q;
        en_eff  = load_first ? tub_en : shadow_en_q;

        shadow_seg_d = (load_first || load_frame) ? seg_in : shadow_seg_q;
        shadow_en_d  = (load_first || load_frame) ? tub_en : shadow_en_q;

        if (!enable) begin
            idx_d = 2'd0;
        end else if (slot_wrap) begin
            idx_d = idx_q + 2'd1;
        end else begin
            idx_d = idx_q;
        end

        digit_l = {1'b0, idx_q};
        digit_r = {1'b1, idx_q};

        seg_l_d   = SEG_BLANK;
        seg_r_d   = SEG_BLANK;
        tub_sel_d = '0;
        if (enable && (state == ST_SHOW)) begin
            seg_l_d            = seg_eff[{digit_l, 3'b000} +: 8];
            seg_r_d            = seg_eff[{digit_r, 3'b000} +: 8];
            tub_sel_d[digit_l] = en_eff[digit_l];
            tub_sel_d[digit_r] = en_eff[digit_r];
        end

        frame_done_d = load_frame;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q         <= 1'b0;
            idx_q        <= 2'd0;
            shadow_seg_q <= '0;
            shadow_en_q  <= '0;
            seg_l_q      <= SEG_BLANK;
            seg_r_q      <= SEG_BLANK;
            tub_sel_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            en_q         <= enable;
            idx_q        <= idx_d;
            shadow_seg_q <= shadow_seg_d;
            shadow_en_q  <= shadow_en_d;
            seg_l_q      <= seg_l_d;
            seg_r_q      <= seg_r_d;
            tub_sel_q    <= tub_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_l      = seg_l_q;
    assign seg_r      = seg_r_q;
    assign tub_sel    = tub_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tube_scan_driver.sv
// Directed bench for tube_scan_driver with SCAN_DIV=8, BLANK_CYC=2.
// Expectations follow TUBE_SCAN_BLANK_EN so either build can be checked.
module tb_tube_scan_driver;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 4 * SCAN_DIV;

`ifdef TUBE_SCAN_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    localparam logic [63:0] S1 = 64'hE0BEB660_F2DA60FC;
    localparam logic [63:0] S2 = 64'h01020304_05060708;
    localparam logic [63:0] S3 = 64'h11223344_55667788;
    localparam logic [63:0] S4 = 64'hA1B2C3D4_E5F60718;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [63:0] seg_in;
    logic [7:0]  tub_en;
    logic [7:0]  seg_l;
    logic [7:0]  seg_r;
    logic [7:0]  tub_sel;
    logic        frame_done;

    int n_cmp  = 0;
    int n_fail = 0;

    tube_scan_driver #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .seg_in     (seg_in),
        .tub_en     (tub_en),
        .seg_l      (seg_l),
        .seg_r      (seg_r),
        .tub_sel    (tub_sel),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " seg_l"}, seg_l, 8'h00);
        chk({tag, " seg_r"}, seg_r, 8'h00);
        chk({tag, " tub_sel"}, tub_sel, 8'h00);
        chk({tag, " frame_done"}, {7'b0, frame_done}, 8'h00);
    endtask

    // Checks ncyc cycles of a frame that started on the next clock edge,
    // optionally changing the inputs right after cycle chg_at is sampled.
    task automatic run_frame(input string name, input logic [63:0] exp_seg,
                             input logic [7:0] exp_en, input int ncyc, input int chg_at,
                             input logic [63:0] chg_seg, input logic [7:0] chg_en);
        for (int c = 0; c < ncyc; c++) begin
            int         s;
            int         k;
            bit         show;
            logic [7:0] e_tub;
            logic [7:0] e_l;
            logic [7:0] e_r;
            string      tag;
            @(posedge clk);
            @(negedge clk);
            s     = c / SCAN_DIV;
            k     = c % SCAN_DIV;
            show  = !(BLANK_ON && (k >= SCAN_DIV - BLANK_CYC));
            e_tub = 8'h00;
            e_l   = 8'h00;
            e_r   = 8'h00;
            if (show) begin
                e_tub[s]     = exp_en[s];
                e_tub[s + 4] = exp_en[s + 4];
                e_l          = exp_seg[s * 8 +: 8];
                e_r          = exp_seg[(s + 4) * 8 +: 8];
            end
            tag = $sformatf("%s c%0d", name, c);
            chk({tag, " tub_sel"}, tub_sel, e_tub);
            chk({tag, " seg_l"}, seg_l, e_l);
            chk({tag, " seg_r"}, seg_r, e_r);
            chk({tag, " frame_done"}, {7'b0, frame_done}, (c == FRAME - 1) ? 8'h01 : 8'h00);
            if (c == chg_at) begin
                seg_in = chg_seg;
                tub_en = chg_en;
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        seg_in = '0;
        tub_en = '0;
        #12;
        chk_zero("reset");

        // Full enables; new inputs arrive in slot 1 and must wait for next frame.
        @(negedge clk);
        rst_n  = 1'b1;
        seg_in = S1;
        tub_en = 8'hFF;
        enable = 1'b1;
        run_frame("f1", S1, 8'hFF, FRAME, SCAN_DIV, S2, 8'h01);

        // Only digit 0 enabled: other slots dark, segments still driven.
        run_frame("f2", S2, 8'h01, FRAME, SCAN_DIV, S3, 8'hFF);

        // Drop enable mid slot 2 and stage a fresh snapshot.
        run_frame("f3", S3, 8'hFF, 2 * SCAN_DIV + 4, -1, '0, '0);
        seg_in = S4;
        tub_en = 8'hA5;
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_zero("disable1");
        @(posedge clk);
        @(negedge clk);
        chk_zero("disable2");

        // Re-enable restarts at slot 0 with the new snapshot.
        enable = 1'b1;
        run_frame("f4", S4, 8'hA5, FRAME, -1, '0, '0);
        run_frame("f5", S4, 8'hA5, 3, -1, '0, '0);

        // Asynchronous reset in the middle of a SHOW cycle.
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        chk_zero("rst_held");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tube_scan_driver.md
TUBE_SCAN_DRIVER -- requirements
Module: tube_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles per digit slot (minimum 4).
REQ-002 SHALL have parameter BLANK_CYC, default 1000, meaning blanked cycles at the end of each slot (minimum 1, less than SCAN_DIV).
REQ-003 SHALL have ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  scanning enabled.
- seg_in  in  64  segment bytes; digit k is bits [8k+7:8k]; encoding {a,b,c,d,e,f,g,dp}, active-high.
- tub_en  in  8  per-digit enable; bit k is digit k.
- seg_l  out  8  segment bus for digits 0-3.
- seg_r  out  8  segment bus for digits 4-7.
- tub_sel  out  8  digit select, active-high, one-hot or zero.
- frame_done  out  1  one-cycle pulse at the end of each 4-slot frame.

Function
REQ-004 SHALL use a slot counter cnt from 0 to SCAN_DIV-1; wrap at SCAN_DIV-1 advances index idx from 0 to 3, then wraps to 0.
REQ-005 SHALL be in state SHOW while cnt < SCAN_DIV-BLANK_CYC, otherwise BLANK.
REQ-006 In SHOW, SHALL drive seg_l = shadow digit idx, seg_r = shadow digit idx+4, and tub_sel bits idx and idx+4 = the corresponding shadow tub_en bits; all other tub_sel bits 0.
REQ-007 In BLANK, SHALL drive tub_sel = 0 and seg_l = seg_r = 0.
REQ-008 Every output SHALL be registered; pins SHALL reflect the cnt/idx state with one cycle of latency.
REQ-009 Shadow registers (64-bit segment, 8-bit enable) SHALL load seg_in and tub_en on the cycle cnt wraps with idx=3, and on the first enabled cycle after enable rises; mid-frame input changes SHALL NOT appear until the next frame.
REQ-010 frame_done SHALL pulse high for exactly one cycle, aligned with the idx 3->0 wrap on the pins.
REQ-011 With enable=0, SHALL hold cnt=0, idx=0, and all outputs 0 on the next cycle; on re-enable, scanning SHALL restart at idx 0, cnt 0.
REQ-012 A tub_en bit of 0 SHALL keep that digit dark while the other digit in the same slot still shows.
REQ-013 cnt width SHALL be $clog2(SCAN_DIV); idx width SHALL be 2 bits, with natural wrap.

Reset
REQ-014 On rst_n low, asynchronously: cnt=0, idx=0, shadows=0, seg_l=seg_r=0, tub_sel=0, frame_done=0.
REQ-015 Deassertion SHALL be synchronized to clk by the surrounding logic; the first SHOW slot follows on the next enabled cycle.

Configuration
REQ-016 Macro TUBE_SCAN_BLANK_EN defined: blanking per REQ-005/REQ-007 is active.
REQ-017 Macro TUBE_SCAN_BLANK_EN undefined: state is always SHOW, BLANK_CYC is ignored, and slot timing and frame_done timing are unchanged.

Structure
REQ-018 Package tube_pkg SHALL hold SEG_BLANK (8'h00), digit glyph constants (SEG_0=8'hFC, etc.), and the SHOW/BLANK state typedef.
REQ-019 Sub-module scan_prescaler SHALL own cnt and emit slot_wrap and in_blank.

Verification
All scenarios use SCAN_DIV=8 and BLANK_CYC=2.
REQ-020 Drive seg_in digit0=8'hFC, digit4=8'h60, tub_en=8'hFF -> slot 0: tub_sel=8'h11, seg_l=FC, seg_r=60 for 6 cycles, then 2 cycles of tub_sel=0.
REQ-021 Drive tub_en=8'h01 -> slot 0: tub_sel=8'h01; slots 1-3: tub_sel=0; segments still driven.
REQ-022 Change seg_in in slot 1 -> outputs keep the old value until after frame_done; the new value appears in the next slot 0.
REQ-023 Deassert enable mid-slot 2 -> all outputs 0 one cycle later; re-enable -> slot 0 restarts with fresh snapshot.
REQ-024 Pulse rst_n low asynchronously mid-SHOW -> outputs 0 immediately, without waiting for clk.
REQ-025 Build without TUBE_SCAN_BLANK_EN -> tub_sel stays non-zero for all 8 cycles of each slot; frame_done period is still 32 cycles.
